// File: rtl/dw_conv_mac_pkg.sv
// Shared CNN package: load-FSM state encoding and datapath latency.
// Imported by the depthwise MAC top level.
package dw_conv_mac_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        LOAD_B = 2'd2,
        RUN    = 2'd3
    } load_state_t;

    // S1 products, S2 sum + bias, S3 requantisation
    localparam int PIPE_LATENCY = 3;

    localparam int SHIFT_WIDTH = 5;

endpackage

// File: rtl/dw_mac_channel.sv
// One depthwise channel: TAPS signed products, adder tree + bias,
// rounding shift, saturation and optional ReLU, three register stages.
// Ports: clk, rstn; en_s1/en_s2/en_s3 stage enables; win/wgt packed taps;
// bias; shift, relu (used at S3); result (holds when en_s3 is low).
module dw_mac_channel #(
    parameter int TAPS       = 9,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         en_s1,
    input  logic                         en_s2,
    input  logic                         en_s3,
    input  logic [TAPS*DATA_WIDTH-1:0]   win,
    input  logic [TAPS*DATA_WIDTH-1:0]   wgt,
    input  logic signed [ACC_WIDTH-1:0]  bias,
    input  logic [4:0]                   shift,
    input  logic                         relu,
    output logic signed [DATA_WIDTH-1:0] result
);

    localparam int PW = 2 * DATA_WIDTH;
    // wide enough that the rounding constant for shift=31 is never lost
    localparam int EW = ACC_WIDTH + 32;

    localparam logic signed [EW-1:0] MAXV =
        EW'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] MINV = ~MAXV;

    logic signed [PW-1:0]         prod_q [TAPS];
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [EW-1:0]         ext;
    logic signed [EW-1:0]         rnd;
    logic signed [EW-1:0]         tot;
    logic signed [EW-1:0]         shf;
    logic signed [DATA_WIDTH-1:0] res;

    // S1: products
    always_ff @(posedge clk) begin
        if (en_s1) begin
            for (int k = 0; k < TAPS; k++) begin
                prod_q[k] <= $signed(win[k*DATA_WIDTH +: DATA_WIDTH])
                           * $signed(wgt[k*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    always_comb begin
        sum = bias;
        for (int k = 0; k < TAPS; k++) begin
            sum = sum + ACC_WIDTH'(prod_q[k]);
        end
    end

    // S2: accumulated sum plus bias
    always_ff @(posedge clk) begin
        if (en_s2) begin
            acc_q <= sum;
        end
    end

    // round-half-up, arithmetic shift, saturate, then ReLU
    always_comb begin
        ext = EW'(acc_q);
        rnd = '0;
        if (shift != 5'd0) begin
            rnd[shift - 5'd1] = 1'b1;
        end
        tot = ext + rnd;
        shf = tot >>> shift;
        if (shf > MAXV) begin
            res = MAXV[DATA_WIDTH-1:0];
        end else if (shf < MINV) begin
            res = MINV[DATA_WIDTH-1:0];
        end else begin
            res = shf[DATA_WIDTH-1:0];
        end
        if (relu && res[DATA_WIDTH-1]) begin
            res = '0;
        end
    end

    // S3: requantised result, held between valid windows
    always_ff @(posedge clk) begin
        if (!rstn) begin
            result <= '0;
        end else if (en_s3) begin
            result <= res;
        end
    end

endmodule

// File: rtl/dw_conv_mac.sv
// Depthwise 3x3 convolution MAC array with serial weight/bias loading.
// Ports: clk, rstn (sync, active-low); win_in/valid_in windows;
// param_in/param_valid/load_start parameter load; shift_ctrl, relu_en
// requantisation; data_out/valid_out results; ready = compute enabled.
module dw_conv_mac
    import dw_conv_mac_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int IN_CHANNEL_NUM  = 9,
    parameter int OUT_CHANNEL_NUM = 18,
    parameter int ACC_WIDTH       = 24
) (
    input  logic clk,
    input  logic rstn,
    input  logic [OUT_CHANNEL_NUM*IN_CHANNEL_NUM*DATA_WIDTH-1:0] win_in,
    input  logic                                   valid_in,
    input  logic [ACC_WIDTH-1:0]                   param_in,
    input  logic                                   param_valid,
    input  logic                                   load_start,
    input  logic [SHIFT_WIDTH-1:0]                 shift_ctrl,
    input  logic                                   relu_en,
    output logic [OUT_CHANNEL_NUM*DATA_WIDTH-1:0]  data_out,
    output logic                                   valid_out,
    output logic                                   ready
);

    localparam int NW = OUT_CHANNEL_NUM * IN_CHANNEL_NUM;
    localparam int CW = $clog2(NW);
    localparam int SW = IN_CHANNEL_NUM * DATA_WIDTH;

    load_state_t state_q;
    load_state_t state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic [NW*DATA_WIDTH-1:0]    wgt_q;
    logic signed [ACC_WIDTH-1:0] bias_q [OUT_CHANNEL_NUM];

    logic                    accept;
    logic                    wr_w;
    logic                    wr_b;
    logic [PIPE_LATENCY-1:0] vld_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= {vld_q[PIPE_LATENCY-2:0], accept};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (load_start) begin
            state_d = LOAD_W;
            cnt_d   = '0;
        end else begin
            case (state_q)
                LOAD_W: begin
                    if (param_valid) begin
                        if (cnt_q == CW'(NW - 1)) begin
                            state_d = LOAD_B;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (param_valid) begin
                        if (cnt_q == CW'(OUT_CHANNEL_NUM - 1)) begin
                            state_d = RUN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // a load_start pulse restarts the load, so it also blocks the write
    assign wr_w = rstn && param_valid && !load_start && (state_q == LOAD_W);
    assign wr_b = rstn && param_valid && !load_start && (state_q == LOAD_B);

    // parameter storage is deliberately not reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NW; i++) begin
            if (wr_w && cnt_q == CW'(i)) begin
                wgt_q[i*DATA_WIDTH +: DATA_WIDTH] <= param_in[DATA_WIDTH-1:0];
            end
        end
        for (int c = 0; c < OUT_CHANNEL_NUM; c++) begin
            if (wr_b && cnt_q == CW'(c)) begin
                bias_q[c] <= param_in;
            end
        end
    end

    assign accept    = valid_in && (state_q == RUN);
    assign ready     = (state_q == RUN);
    assign valid_out = vld_q[PIPE_LATENCY-1];

    for (genvar c = 0; c < OUT_CHANNEL_NUM; c++) begin : g_ch
        dw_mac_channel #(
            .TAPS       (IN_CHANNEL_NUM),
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_ch (
            .clk    (clk),
            .rstn   (rstn),
            .en_s1  (accept),
            .en_s2  (vld_q[0]),
            .en_s3  (vld_q[1]),
            .win    (win_in[c*SW +: SW]),
            .wgt    (wgt_q[c*SW +: SW]),
            .bias   (bias_q[c]),
            .shift  (shift_ctrl),
            .relu   (relu_en),
            .result (data_out[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_dw_conv_mac.sv
// Scoreboard bench for dw_conv_mac: random windows and parameters
// against a plain-arithmetic reference model; monitor pops and compares.
module tb_dw_conv_mac;

    localparam int DW = 8;
    localparam int IC = 9;
    localparam int OC = 18;
    localparam int AW = 24;
    localparam int OW = OC * DW;

    logic                clk = 1'b0;
    logic                rstn;
    logic [OC*IC*DW-1:0] win_in;
    logic                valid_in;
    logic [AW-1:0]       param_in;
    logic                param_valid;
    logic                load_start;
    logic [4:0]          shift_ctrl;
    logic                relu_en;
    logic [OW-1:0]       data_out;
    logic                valid_out;
    logic                ready;

    dw_conv_mac #(
        .DATA_WIDTH      (DW),
        .IN_CHANNEL_NUM  (IC),
        .OUT_CHANNEL_NUM (OC),
        .ACC_WIDTH       (AW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .win_in      (win_in),
        .valid_in    (valid_in),
        .param_in    (param_in),
        .param_valid (param_valid),
        .load_start  (load_start),
        .shift_ctrl  (shift_ctrl),
        .relu_en     (relu_en),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [OW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b0;
    logic [OW-1:0] last_exp = '0;

    // model: 0 idle, 1 taking weights, 2 taking biases, 3 computing
    int m_phase = 0;
    int m_cnt = 0;
    int w_ref [OC][IC];
    int b_ref [OC];
    int wm [OC][IC];
    int bm [OC];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [OW-1:0] ref_out(
        input logic [OC*IC*DW-1:0] win, input int sh, input bit relu);
        logic [OW-1:0] o;
        o = '0;
        for (int c = 0; c < OC; c++) begin
            logic signed [63:0] s;
            logic signed [DW-1:0] x;
            s = b_ref[c];
            for (int k = 0; k < IC; k++) begin
                x = win[(c*IC+k)*DW +: DW];
                s = s + 64'(x) * 64'(w_ref[c][k]);
            end
            if (sh > 0) s = s + (64'sd1 <<< (sh - 1));
            s = s >>> sh;
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            if (relu && s < 0) s = 0;
            o[c*DW +: DW] = s[DW-1:0];
        end
        return o;
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (!rstn) begin
            m_phase = 0;
            m_cnt = 0;
            sbq.delete();
            last_exp = '0;
        end else begin
            if (m_phase == 3 && valid_in) begin
                e.cyc = cyc + 2;
                e.data = ref_out(win_in, int'(shift_ctrl), relu_en);
                sbq.push_back(e);
            end
            if (load_start) begin
                m_phase = 1;
                m_cnt = 0;
            end else if (param_valid && m_phase == 1) begin
                w_ref[m_cnt / IC][m_cnt % IC] = int'($signed(param_in[DW-1:0]));
                m_cnt++;
                if (m_cnt == OC * IC) begin
                    m_phase = 2;
                    m_cnt = 0;
                end
            end else if (param_valid && m_phase == 2) begin
                b_ref[m_cnt] = int'($signed(param_in));
                m_cnt++;
                if (m_cnt == OC) begin
                    m_phase = 3;
                    m_cnt = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_out due=%0d now=%0d", e.cyc, cyc);
            end
            checks++;
            if (ready !== (m_phase == 3)) begin
                errors++;
                $display("FAIL ready act=%0b exp=%0b cyc=%0d",
                         ready, (m_phase == 3), cyc);
            end
            if (valid_out) begin
                checks++;
                if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                    e = sbq.pop_front();
                    if (data_out !== e.data) begin
                        errors++;
                        $display("FAIL data cyc=%0d act=%h exp=%h",
                                 cyc, data_out, e.data);
                    end
                    last_exp = e.data;
                end else begin
                    errors++;
                    $display("FAIL unexpected_valid cyc=%0d act=1 exp=0", cyc);
                end
            end else begin
                checks++;
                if (data_out !== last_exp) begin
                    errors++;
                    $display("FAIL hold cyc=%0d act=%h exp=%h",
                             cyc, data_out, last_exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic rand_win();
        for (int i = 0; i < OC * IC; i++) begin
            win_in[i*DW +: DW] = 8'($urandom);
        end
    endtask

    task automatic set_tap(input int c, input int k, input logic [DW-1:0] v);
        win_in[(c*IC+k)*DW +: DW] = v;
    endtask

    task automatic fill_params(input int w, input int b);
        for (int c = 0; c < OC; c++) begin
            bm[c] = b;
            for (int k = 0; k < IC; k++) wm[c][k] = w;
        end
    endtask

    task automatic rand_params();
        for (int c = 0; c < OC; c++) begin
            bm[c] = $urandom_range(2097152) - 1048576;
            for (int k = 0; k < IC; k++) wm[c][k] = $urandom_range(255) - 128;
        end
    endtask

    // valid_in toggles randomly throughout so loading must ignore it
    task automatic load_params();
        load_start = 1'b1;
        param_valid = 1'b0;
        valid_in = 1'($urandom);
        tick();
        load_start = 1'b0;
        for (int i = 0; i < OC * IC; i++) begin
            if ($urandom_range(3) == 0) begin
                param_valid = 1'b0;
                valid_in = 1'($urandom);
                rand_win();
                tick();
            end
            param_in = {16'($urandom), 8'(wm[i / IC][i % IC])};
            param_valid = 1'b1;
            valid_in = 1'($urandom);
            rand_win();
            tick();
        end
        for (int c = 0; c < OC; c++) begin
            if ($urandom_range(3) == 0) begin
                param_valid = 1'b0;
                tick();
            end
            param_in = 24'(bm[c]);
            param_valid = 1'b1;
            valid_in = 1'($urandom);
            tick();
        end
        param_valid = 1'b0;
        valid_in = 1'b0;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            valid_in = 1'($urandom_range(3) != 0);
            param_valid = 1'($urandom);
            param_in = 24'($urandom);
            rand_win();
            tick();
        end
        valid_in = 1'b0;
        param_valid = 1'b0;
    endtask

    task automatic drain();
        valid_in = 1'b0;
        repeat (4) tick();
    endtask

    task automatic one_window();
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rstn = 1'b0;
        win_in = '0;
        valid_in = 1'b0;
        param_in = '0;
        param_valid = 1'b0;
        load_start = 1'b0;
        shift_ctrl = '0;
        relu_en = 1'b0;
        @(negedge clk);
        tick();
        tick();
        mon_en = 1'b1;
        chk("reset_ready", OW'(ready), '0);
        chk("reset_valid", OW'(valid_out), '0);
        chk("reset_data", data_out, '0);
        rstn = 1'b1;

        // param_valid and valid_in in IDLE are ignored
        for (int i = 0; i < 5; i++) begin
            param_valid = 1'b1;
            param_in = 24'($urandom);
            valid_in = 1'b1;
            rand_win();
            tick();
        end
        param_valid = 1'b0;
        valid_in = 1'b0;
        tick();
        chk("idle_not_ready", OW'(ready), '0);

        fill_params(1, 0);
        load_params();
        chk("ready_after_load", OW'(ready), OW'(1));

        rand_win();
        for (int k = 0; k < IC; k++) set_tap(0, k, 8'(k + 1));
        one_window();
        chk("sum45", OW'(data_out[7:0]), OW'(45));
        tick();

        shift_ctrl = 5'd2;
        win_in = '0;
        set_tap(0, 0, 8'd6);
        set_tap(1, 0, 8'hFA);
        one_window();
        chk("round_pos", OW'(data_out[7:0]), OW'(2));
        chk("round_neg", OW'(data_out[15:8]), OW'(8'hFF));
        tick();
        shift_ctrl = 5'd0;

        fill_params(127, 0);
        load_params();
        for (int i = 0; i < OC * IC; i++) win_in[i*DW +: DW] = 8'd127;
        one_window();
        chk("sat_pos", OW'(data_out[7:0]), OW'(127));
        tick();
        relu_en = 1'b1;
        for (int i = 0; i < OC * IC; i++) win_in[i*DW +: DW] = 8'h80;
        one_window();
        chk("relu_zero", OW'(data_out[7:0]), OW'(0));
        tick();
        relu_en = 1'b0;
        one_window();
        chk("sat_neg", OW'(data_out[7:0]), OW'(8'h80));
        tick();

        rand_params();
        load_params();
        for (int r = 0; r < 8; r++) begin
            shift_ctrl = (r == 6) ? 5'd31 : 5'($urandom_range(14));
            relu_en = 1'($urandom);
            stream(30);
            drain();
        end

        // back-to-back windows, reload requested mid-burst
        shift_ctrl = 5'd6;
        for (int i = 0; i < 20; i++) begin
            valid_in = 1'b1;
            load_start = (i == 10);
            rand_win();
            tick();
        end
        load_start = 1'b0;
        valid_in = 1'b0;
        chk("ready_during_reload", OW'(ready), '0);
        rand_params();
        load_params();
        stream(30);
        drain();

        // reset mid-stream
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1;
            rand_win();
            tick();
        end
        rstn = 1'b0;
        tick();
        chk("rst_mid_ready", OW'(ready), '0);
        chk("rst_mid_valid", OW'(valid_out), '0);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            valid_in = 1'b1;
            rand_win();
            tick();
        end
        valid_in = 1'b0;
        chk("post_rst_ready", OW'(ready), '0);
        rand_params();
        shift_ctrl = 5'd4;
        load_params();
        stream(25);
        drain();

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL leftover act=%0d exp=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
